// File: rtl/mem_access_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_pkg : shared types, func3 codes and legality rule for the       |
// |                  memory-access stage                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 255;

  // Unsigned widths exist only for loads; natural alignment is required.
  function automatic logic access_legal(input logic [2:0] f3, input logic store,
                                        input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lo[0];
      F3_W:    ok = (lo == 2'b00);
      F3_BU:   ok = ~store;
      F3_HU:   ok = ~store & ~lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_extend : byte/half lane select with sign or zero extension            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  adr,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (adr)
      2'd0: w_byte = rdata[7:0];
      2'd1: w_byte = rdata[15:8];
      2'd2: w_byte = rdata[23:16];
      2'd3: w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    w_half = adr[1] ? rdata[31:16] : rdata[15:0];
    case (func3)
      F3_B:    data = {{24{w_byte[7]}}, w_byte};
      F3_H:    data = {{16{w_half[15]}}, w_half};
      F3_BU:   data = {24'h0, w_byte};
      F3_HU:   data = {16'h0, w_half};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit : turns one controller access into one bus transaction,    |
// |                   with misalignment rejection and bus timeout              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        is_fetch,
  input  logic [31:0] adr,
  input  logic [31:0] pc,
  input  logic [31:0] wdata,
  input  logic [2:0]  func3,
  output logic        stall,
  output logic        ready,
  output logic [31:0] instr,
  output logic [31:0] old_pc,
  output logic [31:0] data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  // Value the counter holds in the last cycle before the abort fires.
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_lo;
  logic [2:0]  r_f3;
  logic        r_fetch;
  logic        r_store;
  logic [31:0] r_pc;

  logic        w_store;
  logic [2:0]  w_f3;
  logic [3:0]  w_be;
  logic [31:0] w_wrep;
  logic [31:0] w_ext;
  logic [7:0]  w_cnt_inc;

  always_comb begin
    w_store   = we & ~is_fetch;
    w_f3      = is_fetch ? F3_W : func3;
    w_be      = 4'b1111;
    w_wrep    = 32'h0;
    w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    if (w_store) begin
      case (w_f3)
        F3_B: begin
          w_be   = 4'b0001 << adr[1:0];
          w_wrep = {4{wdata[7:0]}};
        end
        F3_H: begin
          w_be   = 4'b0011 << {adr[1], 1'b0};
          w_wrep = {2{wdata[15:0]}};
        end
        default: begin
          w_be   = 4'b1111;
          w_wrep = wdata;
        end
      endcase
    end
  end

  load_extend u_load_extend (
    .rdata (bus_rdata),
    .adr   (r_lo),
    .func3 (r_f3),
    .data  (w_ext)
  );

  assign stall = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_lo       <= 2'd0;
      r_f3       <= 3'd0;
      r_fetch    <= 1'b0;
      r_store    <= 1'b0;
      r_pc       <= 32'h0;
      ready      <= 1'b0;
      instr      <= 32'h0;
      old_pc     <= 32'h0;
      data       <= 32'h0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_be     <= 4'h0;
      bus_wdata  <= 32'h0;
    end else begin
      ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            bus_err <= 1'b0;
            if (access_legal(w_f3, w_store, adr[1:0])) begin
              r_state    <= ST_ADDR;
              misaligned <= 1'b0;
              r_cnt      <= 8'd0;
              r_lo       <= adr[1:0];
              r_f3       <= w_f3;
              r_fetch    <= is_fetch;
              r_store    <= w_store;
              r_pc       <= pc;
              bus_req    <= 1'b1;
              bus_we     <= w_store;
              bus_addr   <= {adr[31:2], 2'b00};
              bus_be     <= w_be;
              bus_wdata  <= w_wrep;
            end else begin
              r_state    <= ST_DONE;
              misaligned <= 1'b1;
              ready      <= 1'b1;
            end
          end
        end
        // Timeout wins over a grant or response landing in the same cycle.
        ST_ADDR: begin
          r_cnt <= w_cnt_inc;
          if (r_cnt == c_cnt_last) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            ready   <= 1'b1;
            r_state <= ST_DONE;
          end else if (bus_gnt) begin
            bus_req <= 1'b0;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_cnt <= w_cnt_inc;
          if (r_cnt == c_cnt_last) begin
            bus_err <= 1'b1;
            ready   <= 1'b1;
            r_state <= ST_DONE;
          end else if (bus_rvalid) begin
            if (r_fetch) begin
              instr  <= bus_rdata;
              old_pc <= r_pc;
            end else if (!r_store) begin
              data <= w_ext;
            end
            ready   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit : directed and random accesses against a byte-level     |
// |                      reference model of the memory-access stage            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk, rst, req, we, is_fetch;
  logic [31:0] adr, pc, wdata, bus_rdata;
  logic [2:0]  func3;
  logic        bus_gnt, bus_rvalid;
  logic        stall, ready, misaligned, bus_err, bus_req, bus_we;
  logic [31:0] instr, old_pc, data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_instr = 0, m_old_pc = 0, m_data = 0;
  logic        m_mis = 0, m_err = 0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .is_fetch(is_fetch), .adr(adr),
    .pc(pc), .wdata(wdata), .func3(func3), .stall(stall), .ready(ready),
    .instr(instr), .old_pc(old_pc), .data(data), .misaligned(misaligned),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  // ---------------- reference model (byte-level view of an access) ----------
  function automatic int acc_size(input logic f, input logic [2:0] f3);
    if (f) return 4;
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit acc_legal(input logic f, input logic w, input logic [2:0] f3,
                                   input logic [31:0] a);
    int sz;
    sz = acc_size(f, f3);
    if (!f) begin
      if (w && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
      if (!w && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    end
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input int lo, input int sz);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + sz);
    return be;
  endfunction

  function automatic logic [31:0] exp_wrep(input logic [31:0] wd, input int sz);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % sz) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input int lo,
                                           input logic [2:0] f3);
    logic [31:0] v;
    int sz;
    sz = acc_size(1'b0, f3);
    v = 32'h0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(lo + i) +: 8];
    if (!f3[2] && sz < 4 && v[8*sz-1])
      for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- one controller access with a bus responder --------------
  // g: idle ADDR cycles before grant; r: idle RESP cycles before response.
  task automatic run_access(input logic f, input logic w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] p,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int g, input int r, input bit stray);
    bit legal, st, ok;
    int sz, endk;
    legal = acc_legal(f, w, f3, a);
    sz    = acc_size(f, f3);
    st    = w && !f;
    ok    = (g + r + 2) < TO;
    endk  = ok ? g + r + 2 : TO;
    req = 1; is_fetch = f; we = w; func3 = f3; adr = a; pc = p; wdata = wd;
    bus_rdata = rd; bus_gnt = 0; bus_rvalid = 0;
    @(posedge clk); #1;
    req = 0;
    if (!legal) begin
      m_mis = 1; m_err = 0;
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL ill_ready: got %b exp 1", ready); end
      n_vec++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL ill_mis: got %b exp 1", misaligned); end
      n_vec++; if (bus_req !== 1'b0 || bus_err !== 1'b0) begin n_err++; $display("FAIL ill_bus: got req=%b err=%b exp 0 0", bus_req, bus_err); end
      n_vec++; if (data !== m_data || instr !== m_instr) begin n_err++; $display("FAIL ill_regs: got %h/%h exp %h/%h", data, instr, m_data, m_instr); end
      @(posedge clk); #1;
      n_vec++; if ({ready, stall, bus_req, misaligned} !== 4'b0001) begin n_err++; $display("FAIL ill_after: got rdy/stall/req/mis=%b exp 0001", {ready, stall, bus_req, misaligned}); end
      return;
    end
    m_mis = 0; m_err = 0;
    n_vec++; if (misaligned !== 1'b0 || bus_err !== 1'b0) begin n_err++; $display("FAIL accept_clear: got mis=%b err=%b exp 0 0", misaligned, bus_err); end
    n_vec++; if (bus_addr !== {a[31:2], 2'b00}) begin n_err++; $display("FAIL bus_addr: got %h exp %h", bus_addr, {a[31:2], 2'b00}); end
    n_vec++; if (bus_we !== st) begin n_err++; $display("FAIL bus_we: got %b exp %b", bus_we, st); end
    n_vec++; if (bus_be !== (st ? exp_be(int'(a[1:0]), sz) : 4'hF)) begin n_err++; $display("FAIL bus_be: got %b exp %b", bus_be, st ? exp_be(int'(a[1:0]), sz) : 4'hF); end
    if (st) begin
      n_vec++; if (bus_wdata !== exp_wrep(wd, sz)) begin n_err++; $display("FAIL bus_wdata: got %h exp %h", bus_wdata, exp_wrep(wd, sz)); end
    end
    for (int k = 1; k <= endk; k++) begin
      n_vec++; if (bus_req !== (k <= g + 1) || stall !== 1'b1 || ready !== 1'b0) begin n_err++; $display("FAIL cyc%0d: got req/stall/rdy=%b%b%b exp %b10", k, bus_req, stall, ready, k <= g + 1); end
      bus_gnt    = (k == g + 1);
      bus_rvalid = (k == g + r + 2) || (stray && k == g + 1);
      @(posedge clk); #1;
    end
    bus_gnt = 0; bus_rvalid = 0;
    if (ok) begin
      if (f) begin m_instr = rd; m_old_pc = p; end
      else if (!st) m_data = exp_load(rd, int'(a[1:0]), f3);
    end else begin
      m_err = 1;
    end
    n_vec++; if (ready !== 1'b1 || stall !== 1'b1) begin n_err++; $display("FAIL done_ready: got rdy=%b stall=%b exp 1 1", ready, stall); end
    n_vec++; if (bus_err !== m_err || misaligned !== 1'b0 || bus_req !== 1'b0) begin n_err++; $display("FAIL done_flags: got err=%b mis=%b req=%b exp %b 0 0", bus_err, misaligned, bus_req, m_err); end
    n_vec++; if (instr !== m_instr || old_pc !== m_old_pc || data !== m_data) begin n_err++; $display("FAIL done_regs: got %h %h %h exp %h %h %h", instr, old_pc, data, m_instr, m_old_pc, m_data); end
    bus_rvalid = 1; bus_rdata = ~rd;
    @(posedge clk); #1;
    bus_rvalid = 0;
    n_vec++; if (ready !== 1'b0 || stall !== 1'b0 || bus_err !== m_err) begin n_err++; $display("FAIL idle_after: got rdy=%b stall=%b err=%b exp 0 0 %b", ready, stall, bus_err, m_err); end
    n_vec++; if (instr !== m_instr || data !== m_data) begin n_err++; $display("FAIL stray_rvalid: got %h %h exp %h %h", instr, data, m_instr, m_data); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 0; req = 0; we = 0; is_fetch = 0; adr = 0; pc = 0; wdata = 0; func3 = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({stall, ready, misaligned, bus_err, bus_req, bus_we} !== 6'b0) begin n_err++; $display("FAIL reset_bits: got %b exp 000000", {stall, ready, misaligned, bus_err, bus_req, bus_we}); end
    n_vec++; if ({instr, old_pc, data, bus_addr, bus_be, bus_wdata} !== '0) begin n_err++; $display("FAIL reset_regs: got %h %h %h %h %h %h exp 0", instr, old_pc, data, bus_addr, bus_be, bus_wdata); end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    run_access(1'b1, 1'b0, 3'd0, 32'h100, 32'h100, 32'h0, 32'h00500093, 0, 0, 1'b0);
    n_vec++; if (instr !== 32'h00500093 || old_pc !== 32'h100) begin n_err++; $display("FAIL fetch_const: got %h %h exp 00500093 00000100", instr, old_pc); end
  endtask

  task automatic test_load_sign();
    run_access(1'b0, 1'b0, 3'b000, 32'h203, 32'h0, 32'h0, 32'h80FF1234, 0, 0, 1'b1);
    n_vec++; if (data !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_const: got %h exp ffffff80", data); end
    run_access(1'b0, 1'b0, 3'b100, 32'h203, 32'h0, 32'h0, 32'h80FF1234, 1, 0, 1'b0);
    n_vec++; if (data !== 32'h00000080) begin n_err++; $display("FAIL lbu_const: got %h exp 00000080", data); end
  endtask

  task automatic test_store_half();
    run_access(1'b0, 1'b1, 3'b001, 32'h302, 32'h0, 32'h0000ABCD, 32'h0, 0, 1, 1'b0);
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 1'b0, 3'b010, 32'h401, 32'h0, 32'h0, 32'h12345678, 0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_access(1'b0, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 32'hDEADBEEF, 20, 0, 1'b0);
    run_access(1'b0, 1'b0, 3'b010, 32'h504, 32'h0, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    req = 1; is_fetch = 0; we = 0; func3 = 3'b001; adr = 32'h601;
    @(posedge clk); #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_first: got %b exp 1", ready); end
    @(posedge clk); #1;
    n_vec++; if (ready !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got rdy=%b stall=%b exp 0 0", ready, stall); end
    @(posedge clk); #1;
    req = 0;
    n_vec++; if (ready !== 1'b1 || misaligned !== 1'b1) begin n_err++; $display("FAIL b2b_second: got rdy=%b mis=%b exp 1 1", ready, misaligned); end
    @(posedge clk); #1;
    m_mis = 1; m_err = 0;
  endtask

  task automatic test_reset_mid();
    req = 1; is_fetch = 0; we = 0; func3 = 3'b010; adr = 32'h700; bus_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    req = 0; bus_gnt = 1;
    @(posedge clk); #1;
    bus_gnt = 0;
    #2 rst = 0;
    #1;
    m_instr = 0; m_old_pc = 0; m_data = 0; m_mis = 0; m_err = 0;
    n_vec++; if ({stall, ready, misaligned, bus_err, bus_req, bus_we} !== 6'b0) begin n_err++; $display("FAIL rstmid_bits: got %b exp 000000", {stall, ready, misaligned, bus_err, bus_req, bus_we}); end
    n_vec++; if ({instr, old_pc, data, bus_addr, bus_be, bus_wdata} !== '0) begin n_err++; $display("FAIL rstmid_regs: got nonzero %h %h %h exp 0", instr, data, bus_addr); end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    bus_rvalid = 1;
    @(posedge clk); #1;
    bus_rvalid = 0;
    @(posedge clk); #1;
    n_vec++; if (stall !== 1'b0 || ready !== 1'b0 || data !== 32'h0) begin n_err++; $display("FAIL rstmid_late: got stall=%b rdy=%b data=%h exp 0 0 0", stall, ready, data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic f, w, st;
      logic [2:0] f3;
      logic [31:0] a;
      int g, r;
      f  = ($urandom % 4) == 0;
      w  = $urandom % 2;
      f3 = 3'($urandom % 8);
      a  = $urandom;
      if ($urandom % 2) a[1:0] = 2'b00;
      do begin
        g = $urandom % 3;
        r = $urandom % 3;
      end while (g + r + 2 == TO);
      if ($urandom % 8 == 0) g = 6;
      st = w && !f;
      run_access(f, w, f3, a, $urandom, $urandom, $urandom, g, r, ($urandom % 2) == 1);
      if (st) m_data = m_data;
    end
  endtask

  initial begin
    rst = 0;
    test_reset();
    test_fetch();
    test_load_sign();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
